// File: rtl/inst_encoder_if.sv
// Field-bundle handshake and instruction-memory write bus for the instruction encoder.
interface inst_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [2:0]        opcode;
    logic [3:0]        func;
    logic [4:0]        regs;
    logic [4:0]        regt;
    logic [4:0]        shamt;
    logic [25:0]       imm;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    // Producer of field bundles and consumer of memory writes.
    modport master (
        output in_valid, fmt, opcode, func, regs, regt, shamt, imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // The encoder itself.
    modport slave (
        input  in_valid, fmt, opcode, func, regs, regt, shamt, imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_encoder.sv
// Instruction encoder / program loader: packs decoded field bundles into 32-bit
// words and writes them to consecutive instruction-memory addresses.
module inst_encoder #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  prog_len,
    inst_encoder_if.slave     bus,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_written,
    output logic [LEN_W-1:0]  err_cnt,
    output logic              err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [LEN_W-1:0]  errcnt_q, errcnt_d;
    logic              err_q, err_d;

    logic              in_ready_c;
    logic              hs;
    logic              illegal;
    logic [31:0]       word;

    // Field packing and illegal-bundle detection.
    always_comb begin
        word    = '0;
        illegal = (bus.fmt == 2'b11) || (bus.fmt == 2'b01 && bus.imm[25:20] != '0);
        case (bus.fmt)
            2'b00:   word = {bus.opcode, bus.regs, bus.regt, bus.shamt, 10'b0, bus.func};
            2'b01:   word = {bus.opcode, bus.regs, bus.func, bus.imm[19:0]};
            default: word = {bus.opcode, 3'b0, bus.imm};
        endcase
    end

    // Next-state, write-register and counter logic; abort overrides everything else.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        words_d     = words_q;
        errcnt_d    = errcnt_q;
        err_d       = err_q;

        in_ready_c = (state_q == RUN) && (remaining_q != '0) && (!mem_we_q || bus.mem_ready);
        hs         = bus.in_valid && in_ready_c;

        if (state_q != IDLE && abort) begin
            state_d  = IDLE;
            mem_we_d = 1'b0;
        end else begin
            // Completed write drops mem_we; a handshake in the same cycle re-raises it.
            if (mem_we_q && bus.mem_ready) begin
                mem_we_d = 1'b0;
                words_d  = words_q + LEN_W'(1);
            end
            if (hs) begin
                remaining_d = remaining_q - LEN_W'(1);
                if (illegal) begin
                    errcnt_d = errcnt_q + LEN_W'(1);
                    err_d    = 1'b1;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cur_addr_q;
                    mem_wdata_d = word;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                end
            end
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        cur_addr_d  = base_addr;
                        remaining_d = prog_len;
                        words_d     = '0;
                        errcnt_d    = '0;
                        err_d       = 1'b0;
                        state_d     = (prog_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (hs && remaining_q == LEN_W'(1)) state_d = DRAIN;
                end
                DRAIN: begin
                    if (!mem_we_q || bus.mem_ready) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            words_q     <= '0;
            errcnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            words_q     <= words_d;
            errcnt_q    <= errcnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign words_written  = words_q;
    assign err_cnt        = errcnt_q;
    assign err            = err_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: per-format vector table plus hand-written
// sequences for back-to-back writes, backpressure, illegal bundles, wrap,
// zero length, abort and asynchronous reset.
module tb_inst_encoder;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  prog_len = '0;
    logic              busy, done, err;
    logic [LEN_W-1:0]  words_written, err_cnt;

    inst_encoder_if #(.ADDR_W(ADDR_W)) bus_if ();

    inst_encoder #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .prog_len(prog_len), .bus(bus_if),
        .busy(busy), .done(done), .words_written(words_written),
        .err_cnt(err_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [2:0]  op;
        logic [3:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  sh;
        logic [25:0] imm;
        logic [31:0] word;
        logic        legal;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [ADDR_W-1:0] wa_q [$];
    logic [31:0]       wd_q [$];
    int                wc_q [$];

    // Cycle counter for write-spacing checks.
    always @(posedge clk) cyc++;

    // Record every accepted write and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.mem_we && bus_if.mem_ready && !abort) begin
                wa_q.push_back(bus_if.mem_addr);
                wd_q.push_back(bus_if.mem_wdata);
                wc_q.push_back(cyc);
            end
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
        base_addr = b;
        prog_len  = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic set_fields(input vec_t v);
        bus_if.fmt    = v.fmt;
        bus_if.opcode = v.op;
        bus_if.func   = v.fn;
        bus_if.regs   = v.rs;
        bus_if.regt   = v.rt;
        bus_if.shamt  = v.sh;
        bus_if.imm    = v.imm;
    endtask

    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        set_fields(v);
        bus_if.in_valid = 1'b1;
        #1;
        for (int k = 0; k < 50; k++) begin
            if (bus_if.in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        bus_if.in_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("done_seen", 32'(ok), 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b00, 3'b010, 4'h3, 5'd9,  5'd3,  5'd4,  26'h0000000, 32'h49190003, 1'b1};
        vecs[1] = '{2'b01, 3'b001, 4'h5, 5'd1,  5'd0,  5'd0,  26'h0000010, 32'h21500010, 1'b1};
        vecs[2] = '{2'b10, 3'b111, 4'h0, 5'd0,  5'd0,  5'd0,  26'h0000ABC, 32'hE0000ABC, 1'b1};
        vecs[3] = '{2'b00, 3'b111, 4'hF, 5'd31, 5'd31, 5'd31, 26'h3FFFFFF, 32'hFFFFC00F, 1'b1};
        vecs[4] = '{2'b01, 3'b110, 4'hA, 5'd0,  5'd17, 5'd9,  26'h00FFFFF, 32'hC0AFFFFF, 1'b1};
        vecs[5] = '{2'b01, 3'b001, 4'h5, 5'd1,  5'd0,  5'd0,  26'h2000000, 32'h00000000, 1'b0};
        vecs[6] = '{2'b11, 3'b010, 4'h3, 5'd9,  5'd3,  5'd4,  26'h0000000, 32'h00000000, 1'b0};
        vecs[7] = '{2'b10, 3'b000, 4'hF, 5'd31, 5'd31, 5'd31, 26'h3FFFFFF, 32'h03FFFFFF, 1'b1};
        vecs[8] = '{2'b01, 3'b001, 4'h5, 5'd1,  5'd0,  5'd0,  26'h0100000, 32'h00000000, 1'b0};

        bus_if.in_valid  = 1'b0;
        bus_if.mem_ready = 1'b0;
        set_fields(vecs[0]);

        // Reset values while rst_n is held low.
        #3;
        chk("rst_mem_we", 32'(bus_if.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus_if.mem_wdata, 32'd0);
        chk("rst_outs", {27'd0, busy, done, err, bus_if.in_ready, 1'b0}, 32'd0);
        chk("rst_counters", {16'd0, words_written, err_cnt}, 32'd0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table: one single-instruction load per vector.
        for (int i = 0; i < NV; i++) begin
            clear_mon();
            bus_if.mem_ready = 1'b1;
            do_start(8'(8'h40 + i), 8'd1);
            send(vecs[i]);
            wait_done();
            chk($sformatf("v%0d_nwrites", i), 32'(wa_q.size()), vecs[i].legal ? 32'd1 : 32'd0);
            if (vecs[i].legal && wa_q.size() > 0) begin
                chk($sformatf("v%0d_addr", i), 32'(wa_q[0]), 32'(8'h40 + i));
                chk($sformatf("v%0d_data", i), wd_q[0], vecs[i].word);
            end
            chk($sformatf("v%0d_err", i), 32'(err), 32'(!vecs[i].legal));
            chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(!vecs[i].legal));
            chk($sformatf("v%0d_words", i), 32'(words_written), 32'(vecs[i].legal));
        end

        // Mixed formats back to back with memory always ready.
        clear_mon();
        bus_if.mem_ready = 1'b1;
        do_start(8'h20, 8'd2);
        send(vecs[1]);
        send(vecs[2]);
        wait_done();
        chk("mix_nwrites", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            chk("mix_addr0", 32'(wa_q[0]), 32'h20);
            chk("mix_data0", wd_q[0], 32'h21500010);
            chk("mix_addr1", 32'(wa_q[1]), 32'h21);
            chk("mix_data1", wd_q[1], 32'hE0000ABC);
            chk("mix_spacing", 32'(wc_q[1] - wc_q[0]), 32'd1);
        end
        chk("mix_words", 32'(words_written), 32'd2);
        chk("mix_done_pulses", 32'(done_cnt), 32'd1);

        // Backpressure: memory stalls for 3 cycles with the second bundle waiting.
        clear_mon();
        bus_if.mem_ready = 1'b0;
        do_start(8'h20, 8'd2);
        send(vecs[1]);
        set_fields(vecs[2]);
        bus_if.in_valid = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d_mem_we", c), 32'(bus_if.mem_we), 32'd1);
            chk($sformatf("bp%0d_addr", c), 32'(bus_if.mem_addr), 32'h20);
            chk($sformatf("bp%0d_data", c), bus_if.mem_wdata, 32'h21500010);
            chk($sformatf("bp%0d_in_ready", c), 32'(bus_if.in_ready), 32'd0);
            tick();
        end
        bus_if.in_valid = 1'b0;
        bus_if.mem_ready = 1'b1;
        send(vecs[2]);
        wait_done();
        chk("bp_nwrites", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            chk("bp_data0", wd_q[0], 32'h21500010);
            chk("bp_addr1", 32'(wa_q[1]), 32'h21);
            chk("bp_data1", wd_q[1], 32'hE0000ABC);
        end
        chk("bp_words", 32'(words_written), 32'd2);

        // Illegal bundles mixed with one legal R-type.
        clear_mon();
        do_start(8'h30, 8'd3);
        send(vecs[8]);
        send(vecs[6]);
        send(vecs[0]);
        wait_done();
        chk("ill_nwrites", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            chk("ill_addr", 32'(wa_q[0]), 32'h30);
            chk("ill_data", wd_q[0], 32'h49190003);
        end
        chk("ill_err_cnt", 32'(err_cnt), 32'd2);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_words", 32'(words_written), 32'd1);
        chk("ill_done_pulses", 32'(done_cnt), 32'd1);

        // Address wrap from the top of memory.
        clear_mon();
        do_start(8'hFF, 8'd2);
        send(vecs[0]);
        send(vecs[3]);
        wait_done();
        chk("wrap_nwrites", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            chk("wrap_addr0", 32'(wa_q[0]), 32'hFF);
            chk("wrap_addr1", 32'(wa_q[1]), 32'h00);
            chk("wrap_data1", wd_q[1], 32'hFFFFC00F);
        end
        chk("wrap_err_cleared", 32'(err), 32'd0);

        // Zero-length load: straight to DONE with no writes.
        clear_mon();
        do_start(8'h70, 8'd0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        tick();
        chk("len0_done_drop", 32'(done), 32'd0);
        chk("len0_nwrites", 32'(wa_q.size()), 32'd0);
        chk("len0_words", 32'(words_written), 32'd0);

        // Abort with a write stalled in the register.
        clear_mon();
        bus_if.mem_ready = 1'b0;
        do_start(8'h50, 8'd2);
        send(vecs[0]);
        chk("abort_pending", 32'(bus_if.mem_we), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_mem_we", 32'(bus_if.mem_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        bus_if.mem_ready = 1'b1;
        repeat (3) tick();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_nwrites", 32'(wa_q.size()), 32'd0);
        chk("abort_words", 32'(words_written), 32'd0);

        // Asynchronous reset in the middle of a load.
        clear_mon();
        bus_if.mem_ready = 1'b0;
        do_start(8'h60, 8'd3);
        send(vecs[3]);
        chk("arst_pre_mem_we", 32'(bus_if.mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_we", 32'(bus_if.mem_we), 32'd0);
        chk("arst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
        chk("arst_mem_wdata", bus_if.mem_wdata, 32'd0);
        chk("arst_flags", {28'd0, busy, done, err, bus_if.in_ready}, 32'd0);
        chk("arst_counters", {16'd0, words_written, err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("arst_no_done", 32'(done_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
